// File: rtl/botao_debounce.sv
// rtl/botao_debounce.sv - pushbutton synchronizer, debouncer and press event generator
//
// Ports:
//   clock         system clock, all logic on the rising edge
//   reset         synchronous, active-low
//   botao_in      raw active-low pushbutton, asynchronous and bouncing
//   botao_out     debounced active-low level
//   press_pulse   one-cycle strobe per accepted press
//   release_pulse one-cycle strobe per accepted release
//   long_pulse    one-cycle strobe once a press is held LONG_CYCLES
//   press_count   accepted presses, wraps 255 -> 0
//
// Optional feature: define BOTAO_LONG_PRESS_EN to build the long-press hold
// counter; otherwise long_pulse is tied to 0.

module botao_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao_in,
    output logic       botao_out,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 24'hFFFFFF ||
        LONG_CYCLES < 2 || LONG_CYCLES > 28'hFFFFFFF) begin : g_bad_params
        $error("botao_debounce: parameter out of range");
    end

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sync1;
    logic        s;
    logic [23:0] db_cnt;
    logic [23:0] db_cnt_nxt;
    logic        out_nxt;
    logic        press_nxt;
    logic        release_nxt;
    logic [7:0]  count_nxt;

    // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= botao_in;
            s     <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            db_cnt        <= 24'd0;
            botao_out     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_nxt;
            db_cnt        <= db_cnt_nxt;
            botao_out     <= out_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            press_count   <= count_nxt;
        end
    end

    // The sample that moves IDLE/PRESSED into a wait state is not counted;
    // acceptance happens on the DEBOUNCE_CYCLES-th stable sample inside the
    // wait state, which gives the edge k+DEBOUNCE_CYCLES+2 latency.
    always_comb begin
        state_nxt   = state;
        db_cnt_nxt  = db_cnt;
        out_nxt     = botao_out;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        count_nxt   = press_count;
        case (state)
            IDLE: begin
                if (!s) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = 24'd0;
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = PRESSED;
                    db_cnt_nxt = 24'd0;
                    out_nxt    = 1'b0;
                    press_nxt  = 1'b1;
                    count_nxt  = press_count + 8'd1;
                end else begin
                    db_cnt_nxt = db_cnt + 24'd1;
                end
            end
            PRESSED: begin
                if (s) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = 24'd0;
                end
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    state_nxt = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    db_cnt_nxt  = 24'd0;
                    out_nxt     = 1'b1;
                    release_nxt = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 24'd1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = 24'd0;
            end
        endcase
    end

`ifdef BOTAO_LONG_PRESS_EN
    localparam logic [27:0] HOLD_LAST = 28'(LONG_CYCLES - 1);
    localparam logic [27:0] HOLD_MAX  = 28'(LONG_CYCLES);

    logic [27:0] hold_cnt;

    // Counts only while PRESSED and freezes in RELEASE_WAIT, so a bounce that
    // falls back to PRESSED resumes the same hold. It saturates at
    // LONG_CYCLES, which limits long_pulse to once per press. long_pulse only
    // fires from PRESSED, so it can never coincide with the other strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_cnt   <= 28'd0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (state == IDLE || state == PRESS_WAIT) begin
                hold_cnt <= 28'd0;
            end else if (state == PRESSED && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 28'd1;
                if (hold_cnt == HOLD_LAST) begin
                    long_pulse <= 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_botao_debounce.sv
// tb/tb_botao_debounce.sv - scoreboard testbench for botao_debounce

module tb_botao_debounce;

    localparam int D = 4;
    localparam int L = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       botao_in = 1'b1;
    logic       botao_out;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_count = 0;

    // kind: 0 press, 1 release, 2 long; cyc is the edge after which the strobe is high
    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } ev_t;

    ev_t sb[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    botao_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L)
    ) dut (
        .clock(clock),
        .reset(reset),
        .botao_in(botao_in),
        .botao_out(botao_out),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .press_count(press_count)
    );

    task automatic push(input int kind, input int c, input int cnt);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    // Advance n cycles; at each falling edge pop and compare observed strobes.
    task automatic tick(input int n);
        ev_t e;
        int  kind;
        int  np;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            np = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
            checks++;
            if (np > 1) begin
                errors++;
                $display("FAIL pulse_exclusive: cyc %0d has %0d strobes high, required at most 1", cyc, np);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d due at cyc %0d not seen by cyc %0d", e.kind, e.cyc, cyc);
            end
            if (np > 0) begin
                kind = press_pulse ? 0 : (release_pulse ? 1 : 2);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kind %0d at cyc %0d, required none", kind, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind !== kind || e.cyc !== cyc) begin
                        errors++;
                        $display("FAIL event: got kind %0d at cyc %0d, required kind %0d at cyc %0d", kind, cyc, e.kind, e.cyc);
                    end else if (kind == 0 && press_count !== 8'(e.cnt)) begin
                        errors++;
                        $display("FAIL event_count: press_count %0d at press, required %0d", press_count, e.cnt);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        exp_count = 0;
    endtask

    task automatic press_and_hold(input int n);
        botao_in = 1'b0;
        exp_count = (exp_count + 1) % 256;
        push(0, cyc + 1 + D + 2, exp_count);
        tick(n);
    endtask

    task automatic release_btn();
        botao_in = 1'b1;
        push(1, cyc + 1 + D + 2, 0);
        tick(D + 4);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        botao_in = 1'b1;
        tick(2);
        checks++;
        if (botao_out !== 1'b1 || press_pulse !== 1'b0 || release_pulse !== 1'b0 ||
            long_pulse !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: out %b pp %b rp %b lp %b cnt %0d, required 1 0 0 0 0",
                     botao_out, press_pulse, release_pulse, long_pulse, press_count);
        end
        reset = 1'b1;
        exp_count = 0;
        tick(2);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            botao_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
            checks++;
            if (botao_out !== 1'b1) begin
                errors++;
                $display("FAIL bounce_out: botao_out %b at cyc %0d, required 1", botao_out, cyc);
            end
        end
        botao_in = 1'b1;
        tick(D + 4);
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL bounce_count: press_count %0d, required 0", press_count);
        end
    endtask

    task automatic test_press();
        int k;
        botao_in = 1'b0;
        k = cyc + 1;
        exp_count = (exp_count + 1) % 256;
        push(0, k + D + 2, exp_count);
        tick(D + 2);
        checks++;
        if (botao_out !== 1'b1) begin
            errors++;
            $display("FAIL press_early: botao_out %b at cyc %0d, required 1", botao_out, cyc);
        end
        tick(1);
        checks++;
        if (botao_out !== 1'b0 || press_pulse !== 1'b1) begin
            errors++;
            $display("FAIL press_accept: out %b pulse %b at cyc %0d, required 0 1", botao_out, press_pulse, cyc);
        end
        tick(1);
        checks++;
        if (press_pulse !== 1'b0 || press_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL press_after: pulse %b cnt %0d, required 0 %0d", press_pulse, press_count, exp_count);
        end
        release_btn();
        checks++;
        if (botao_out !== 1'b1) begin
            errors++;
            $display("FAIL release_out: botao_out %b, required 1", botao_out);
        end
    endtask

    task automatic test_glitch();
        press_and_hold(D + 4);
        botao_in = 1'b1;
        tick(3);
        botao_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (botao_out !== 1'b0) begin
                errors++;
                $display("FAIL glitch_out: botao_out %b at cyc %0d, required 0", botao_out, cyc);
            end
        end
        release_btn();
        checks++;
        if (botao_out !== 1'b1) begin
            errors++;
            $display("FAIL glitch_release: botao_out %b, required 1", botao_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            press_and_hold(D + 4);
            release_btn();
            if (i >= 255) begin
                checks++;
                if (press_count !== 8'(i % 256)) begin
                    errors++;
                    $display("FAIL wrap_count: after press %0d count %0d, required %0d", i, press_count, i % 256);
                end
            end
        end
    endtask

    task automatic test_reset_midpress();
        int r;
        press_and_hold(D + 4);
        release_btn();
        botao_in = 1'b0;
        // Counter is at 3 after D+2 cycles; reset lands on the would-be accept edge.
        tick(D + 2);
        reset = 1'b0;
        tick(1);
        checks++;
        if (botao_out !== 1'b1 || press_pulse !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL midpress_reset: out %b pulse %b cnt %0d, required 1 0 0",
                     botao_out, press_pulse, press_count);
        end
        reset = 1'b1;
        r = cyc + 1;
        exp_count = 1;
        push(0, r + D + 2, exp_count);
        tick(D + 4);
        checks++;
        if (botao_out !== 1'b0 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL midpress_accept: out %b cnt %0d, required 0 1", botao_out, press_count);
        end
        release_btn();
    endtask

    task automatic test_long();
        int k;
        botao_in = 1'b0;
        k = cyc + 1;
        exp_count = (exp_count + 1) % 256;
        push(0, k + D + 2, exp_count);
`ifdef BOTAO_LONG_PRESS_EN
        push(2, k + D + 2 + L, 0);
`endif
        for (int i = 0; i < D + 3 + 30; i++) begin
            tick(1);
`ifndef BOTAO_LONG_PRESS_EN
            checks++;
            if (long_pulse !== 1'b0) begin
                errors++;
                $display("FAIL long_disabled: long_pulse %b at cyc %0d, required 0", long_pulse, cyc);
            end
`endif
        end
        release_btn();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_press();
        test_glitch();
        test_wrap();
        test_reset_midpress();
        test_long();
        tick(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
